// File: rtl/ysyx_22040931_pipe_stage.sv
// ysyx_22040931_pipe_stage
// Valid/ready pipeline stage with one head register and an optional skid
// register. Supports flush, stall and bubble insertion (nop) with priority
// flush > stall > nop > normal transfer. Occupancy is tracked by a three-state
// machine (EMPTY/ONE/FULL) whose encoding doubles as the out_count value.
//
// SKID=1: two entries, in_ready comes from a flop, so the upstream ready path
//         does not depend combinationally on out_ready.
// SKID=0: one entry, in_ready is combinational (pass-through when the
//         downstream consumes the head in the same cycle).

module ysyx_22040931_pipe_stage #(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       SKID     = 1,
  parameter logic [DATA_W-1:0] NOP_DATA = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              nop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_count
);

  // Occupancy states; the encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Source selected for the head register on the next edge.
  typedef enum logic [1:0] {
    HEAD_HOLD = 2'd0,
    HEAD_IN   = 2'd1,
    HEAD_SKID = 2'd2,
    HEAD_NOP  = 2'd3
  } head_sel_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_skid;
  logic              r_in_ready;

  head_sel_e         w_head_sel;
  logic              w_skid_load;
  logic              w_out_valid_int;
  logic              w_active;
  logic              w_accept;
  logic              w_deliver;

  // State register and registered in_ready (only consumed when SKID=1).
  // NOTE: every clocked assignment uses <= so all flops sample the values of
  // the previous cycle, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != FULL);
    end
  end

  // Handshake outputs: gated off while reset, flush or stall is active.
  // NOTE: each always_comb output gets an unconditional default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_out_valid_int = (r_state != EMPTY);
    w_active        = reset && !flush && !stall;
    out_valid       = w_out_valid_int && w_active;
    in_ready        = 1'b0;
    if (SKID != 0) begin
      in_ready = r_in_ready && w_active && !nop;
    end else begin
      in_ready = (!w_out_valid_int || out_ready) && w_active && !nop;
    end
  end

  // Next-state and datapath-control decode, in control priority order.
  always_comb begin
    w_accept     = in_valid && in_ready;
    w_deliver    = out_valid && out_ready;
    w_state_next = r_state;
    w_head_sel   = HEAD_HOLD;
    w_skid_load  = 1'b0;
    if (flush) begin
      w_state_next = EMPTY;
    end else if (stall) begin
      w_state_next = r_state;
    end else begin
      case (r_state)
        EMPTY: begin
          if (nop) begin
            w_state_next = ONE;
            w_head_sel   = HEAD_NOP;
          end else if (w_accept) begin
            w_state_next = ONE;
            w_head_sel   = HEAD_IN;
          end
        end
        ONE: begin
          if (nop) begin
            // A bubble only replaces the head when the head leaves this cycle.
            if (w_deliver) begin
              w_state_next = ONE;
              w_head_sel   = HEAD_NOP;
            end
          end else if (w_accept && w_deliver) begin
            w_state_next = ONE;
            w_head_sel   = HEAD_IN;
          end else if (w_accept) begin
            // Only reachable with SKID=1: SKID=0 accepts in ONE only when the
            // head is delivered in the same cycle.
            if (SKID != 0) begin
              w_state_next = FULL;
              w_skid_load  = 1'b1;
            end
          end else if (w_deliver) begin
            w_state_next = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low in FULL, so only a delivery can move the state.
          if (w_deliver) begin
            w_state_next = ONE;
            w_head_sel   = HEAD_SKID;
          end
        end
        default: begin
          w_state_next = EMPTY;
        end
      endcase
    end
  end

  // Payload registers: head feeds out_data, skid holds the second entry.
  // NOTE: the payload registers are reset on purpose because out_data is
  // observable and must read zero after reset; do not drop this reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      case (w_head_sel)
        HEAD_IN:   r_head <= in_data;
        HEAD_SKID: r_head <= r_skid;
        HEAD_NOP:  r_head <= NOP_DATA;
        default:   r_head <= r_head;
      endcase
      if (w_skid_load) begin
        r_skid <= in_data;
      end
    end
  end

  assign out_data  = r_head;
  assign out_count = r_state;

endmodule

// File: doc/ysyx_22040931_pipe_stage.md
YSYX_22040931_PIPE_STAGE -- requirements
Module: ysyx_22040931_pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64: payload width in bits, legal range 1..512.
REQ-002 SHALL have parameter SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
REQ-003 SHALL have parameter NOP_DATA, default all-zero, DATA_W bits: payload of an inserted bubble.
REQ-004 SHALL have port clock, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low.
REQ-006 SHALL have port flush, input, 1 bit: discard all held entries.
REQ-007 SHALL have port stall, input, 1 bit: freeze the stage.
REQ-008 SHALL have port nop, input, 1 bit: insert one bubble instead of accepting input.
REQ-009 SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-010 SHALL have port in_ready, output, 1 bit: stage accepts in_data this cycle.
REQ-011 SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-014 SHALL have port out_data, output, DATA_W bits: head-entry payload.
REQ-015 SHALL have port out_count, output, 2 bits: number of held entries, 0..2.

Function
REQ-016 SHALL define acceptance as in_valid&&in_ready and delivery as out_valid&&out_ready, each sampled at the rising edge.
REQ-017 SHALL hold entries in a main register (head) and, when SKID=1, a skid register; a state machine with states EMPTY, ONE and FULL tracks occupancy; FULL is unreachable when SKID=0.
REQ-018 SHALL deliver entries in strict acceptance order, with no loss and no duplication.
REQ-019 SHALL apply control priority flush > stall > nop > normal transfer.
REQ-020 SHALL, on flush=1: next state EMPTY, out_count=0; in_ready=0 and out_valid=0 in the flush cycle; no acceptance or delivery counts.
REQ-021 SHALL, on stall=1 (flush=0): drive in_ready=0 and out_valid=0 and leave state, contents and out_data unchanged.
REQ-022 SHALL, on nop=1 (flush=0, stall=0): drive in_ready=0; if the state is EMPTY, or is ONE with delivery this cycle, load NOP_DATA into the head with state ONE; otherwise keep the state unchanged (no bubble queued).
REQ-023 SHALL drive out_valid=1 exactly when the state is ONE or FULL and stall=0 and flush=0.
REQ-024 SHALL drive out_data from the head register at all times.
REQ-025 SHALL, when SKID=1, drive in_ready from a flop equal to (next state != FULL), gated to 0 by stall, nop or flush.
REQ-026 SHALL, when SKID=0, drive in_ready = (!out_valid_internal || out_ready) && !stall && !nop && !flush.
REQ-027 SHALL make these normal transitions: EMPTY+accept -> ONE, with the head loaded.
REQ-028 SHALL make these normal transitions: ONE+accept+deliver -> ONE, with the head loaded from in_data.
REQ-029 SHALL make these normal transitions: ONE+accept, no deliver -> FULL, with the skid loaded (SKID=1 only).
REQ-030 SHALL make these normal transitions: ONE+deliver, no accept -> EMPTY.
REQ-031 SHALL make these normal transitions: FULL+deliver -> ONE, with the skid moved to the head.
REQ-032 SHALL accept nothing in FULL, because in_ready=0.
REQ-033 SHALL give the stage a latency of 1 cycle from acceptance to out_valid when the stage is EMPTY.
REQ-034 SHALL sustain throughput of 1 transfer per cycle with out_ready held high.
REQ-035 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-036 SHALL keep out_count equal to occupancy: EMPTY=0, ONE=1, FULL=2.

Reset
REQ-037 SHALL, while reset=0 at a rising edge, set state EMPTY, out_count=0, out_data=0, skid register=0 and in_ready flop=0, and drive out_valid=0.
REQ-038 SHALL hold in_ready=0 while reset is asserted, and (SKID=1) drive in_ready=1 at the first edge after reset deasserts, with stall, nop and flush low.
REQ-039 SHALL, when reset is asserted mid-operation, discard all entries at the next edge, with no delivery in that cycle.

Verification
REQ-040 SHALL cover: SKID=1, DATA_W=64, out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on consecutive cycles starting 1 cycle after the first acceptance, out_count=1 throughout.
REQ-041 SHALL cover: SKID=1, out_ready=0, offer 0xA then 0xB -> both accepted, out_count=2, in_ready=0; then raise out_ready -> 0xA delivered, then 0xB; in_ready returns to 1 one cycle after the first delivery.
REQ-042 SHALL cover: SKID=0 in EMPTY, nop=1 for 1 cycle with NOP_DATA=0x13 -> out_valid=1 and out_data=0x13 next cycle, in_ready=0 during nop, and the upstream entry is not lost.
REQ-043 SHALL cover: out_count=2, flush=1 together with in_valid=1 -> next cycle out_count=0, out_valid=0, and the offered data is not accepted.
REQ-044 SHALL cover: out_count=1 holding 0x55, stall=1 for 3 cycles with out_ready=1 -> out_valid=0 and in_ready=0 throughout, 0x55 delivered in the first cycle after stall falls.
REQ-045 SHALL cover: out_count=2, reset=0 for 1 cycle -> out_count=0, out_data=0, no delivery; in_ready=1 the following cycle.
